// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-pattern detector with a configurable pattern,
// overlap mode, run-time pattern reload, a registered match flag and a
// saturating match counter.
//
// Handshake: din_valid qualifies din_bit. A bit is consumed on a rising edge
// only when din_valid=1. With din_valid=0 the detector holds its history and
// fill state, and dout_bit stays 0. There is no back-pressure; the detector
// always accepts.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din_bit,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               clr_cnt,
  output logic               dout_bit,
  output logic               dout_reg,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  // The oldest history bit is shifted out before it is ever compared, so only
  // PAT_LEN-1 history bits are stored; the incoming bit completes the window.
  localparam int                HIST_W    = PAT_LEN - 1;
  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // fill is the FSM state: number of valid bits seen since reset, reload or
  // a consuming (non-overlap) match, saturating at PAT_LEN.
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic               dout_reg_q, dout_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [PAT_LEN-1:0] window;
  logic               match;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) fill_q <= '0;
    else      fill_q <= fill_d;
  end

  // FSM next state: reload and consuming matches restart the fill count
  always_comb begin
    fill_d = fill_q;
    if (cfg_we) begin
      fill_d = '0;
    end else if (din_valid) begin
      if (match && (OVERLAP == 0))  fill_d = '0;
      else if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
    end
  end

  // FSM output: Mealy match on the bit currently presented
  always_comb begin
    window   = {hist_q, din_bit};
    match    = din_valid && (fill_q >= FILL_ARM) && (window == pat_q);
    dout_bit = rst && match;
  end

  // Datapath next state: history shift, pattern reload, registered flag, counter
  always_comb begin
    hist_d     = hist_q;
    pat_d      = pat_q;
    dout_reg_d = dout_bit;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    if (din_valid) hist_d = HIST_W'({hist_q, din_bit});
    if (cfg_we)    pat_d  = cfg_pattern;
    if (clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (dout_bit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) sat_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q     <= '0;
      pat_q      <= PATTERN;
      dout_reg_q <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      pat_q      <= pat_d;
      dout_reg_q <= dout_reg_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
    end
  end

  assign dout_reg  = dout_reg_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed vectors for three detector instances sharing
// one input stream: a (overlap, 8-bit counter), b (non-overlap), c (overlap,
// 2-bit counter).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       din_bit;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       clr_cnt;

  logic       dout_bit_a, dout_reg_a, cnt_sat_a;
  logic [7:0] match_cnt_a;
  logic       dout_bit_b, dout_reg_b, cnt_sat_b;
  logic [7:0] match_cnt_b;
  logic       dout_bit_c, dout_reg_c, cnt_sat_c;
  logic [1:0] match_cnt_c;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_bit(din_bit),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
    .dout_bit(dout_bit_a), .dout_reg(dout_reg_a), .match_cnt(match_cnt_a), .cnt_sat(cnt_sat_a)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_bit(din_bit),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
    .dout_bit(dout_bit_b), .dout_reg(dout_reg_b), .match_cnt(match_cnt_b), .cnt_sat(cnt_sat_b)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_bit(din_bit),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt),
    .dout_bit(dout_bit_c), .dout_reg(dout_reg_c), .match_cnt(match_cnt_c), .cnt_sat(cnt_sat_c)
  );

  // scoreboard helper
  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one clock of stimulus; Mealy outputs checked mid-cycle, registered
  // flag checked just after the edge. Instance c shares a's overlap behaviour.
  task automatic run_cycle(input logic r, input logic v, input logic b,
                           input logic we, input logic [3:0] pat, input logic clr,
                           input logic ea, input logic eb, input bit chk_b);
    rst = r; din_valid = v; din_bit = b;
    cfg_we = we; cfg_pattern = pat; clr_cnt = clr;
    #4;
    chk("dout_bit_a", int'(dout_bit_a), int'(ea));
    chk("dout_bit_c", int'(dout_bit_c), int'(ea));
    if (chk_b) chk("dout_bit_b", int'(dout_bit_b), int'(eb));
    @(posedge clk);
    #1;
    chk("dout_reg_a", int'(dout_reg_a), int'(ea));
    if (chk_b) chk("dout_reg_b", int'(dout_reg_b), int'(eb));
  endtask

  task automatic bit_in(input logic b, input logic ea);
    run_cycle(1'b1, 1'b1, b, 1'b0, 4'h0, 1'b0, ea, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic r;
    logic v;
    logic b;
    logic ea;
    logic eb;
    int   ca;
    int   cb;
  } vec_t;

  vec_t vecs[26];
  int   base_a;

  initial begin
    rst = 1'b0; din_valid = 1'b0; din_bit = 1'b0;
    cfg_we = 1'b0; cfg_pattern = 4'h0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;

    // reset; 1011011 on both overlap modes; gap; reset mid-pattern
    vecs = '{
      '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b0, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b1,1'b1, 1,1},
      '{1'b1,1'b1,1'b0, 1'b0,1'b0, 1,1},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 1,1},
      '{1'b1,1'b1,1'b1, 1'b1,1'b0, 2,1},
      '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b0, 1'b0,1'b0, 0,0},
      '{1'b1,1'b0,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b0,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b0,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b1,1'b1, 1,1},
      '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b0, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b0, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0},
      '{1'b1,1'b1,1'b1, 1'b1,1'b1, 1,1}
    };

    for (int i = 0; i < 26; i++) begin
      run_cycle(vecs[i].r, vecs[i].v, vecs[i].b, 1'b0, 4'h0, 1'b0,
                vecs[i].ea, vecs[i].eb, 1'b1);
      chk("match_cnt_a", int'(match_cnt_a), vecs[i].ca);
      chk("match_cnt_b", int'(match_cnt_b), vecs[i].cb);
      chk("match_cnt_c", int'(match_cnt_c), vecs[i].ca);
      chk("cnt_sat_a", int'(cnt_sat_a), 0);
      chk("cnt_sat_c", int'(cnt_sat_c), 0);
    end

    // pattern reload: old pattern still matches in the load cycle, fill restarts
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("cfg_old_pat_cnt_a", int'(match_cnt_a), 1);
    base_a = int'(match_cnt_a);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("cfg_new_pat_cnt_a", int'(match_cnt_a), base_a + 1);
    chk("cfg_new_pat_cnt_b", int'(match_cnt_b), 2);

    // saturating counter on the 2-bit instance, then clear racing a match
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b1);
    chk("sat_m1_cnt_c", int'(match_cnt_c), 1);
    chk("sat_m1_sat_c", int'(cnt_sat_c), 0);
    for (int k = 2; k <= 4; k++) begin
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b1);
      chk("sat_cnt_c", int'(match_cnt_c), (k >= 3) ? 3 : k);
      chk("sat_flag_c", int'(cnt_sat_c), (k >= 3) ? 1 : 0);
      chk("sat_cnt_a", int'(match_cnt_a), k);
      chk("sat_flag_a", int'(cnt_sat_a), 0);
    end
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_cnt_c", int'(match_cnt_c), 0);
    chk("clr_sat_c", int'(cnt_sat_c), 0);
    chk("clr_cnt_a", int'(match_cnt_a), 0);
    chk("clr_dout_reg_c", int'(dout_reg_c), 1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b1);
    chk("after_clr_cnt_c", int'(match_cnt_c), 1);
    chk("after_clr_sat_c", int'(cnt_sat_c), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. It generalises the single fixed-sequence Mealy detector to a configurable pattern length and value, a selectable overlap mode, and a run-time pattern reload. It also adds input qualification, a registered output and a saturating match counter. It sits on a serial bit stream and flags pattern occurrences to downstream control logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, reset value of the pattern register; PAT_LEN bits wide; the MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = bits in a match are consumed.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-low reset
din_valid  input  1  qualifies din_bit; when 0, the detector holds its state
din_bit  input  1  serial data bit
cfg_we  input  1  loads cfg_pattern into the pattern register
cfg_pattern  input  PAT_LEN  new pattern value
clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat
dout_bit  output  1  Mealy match flag, combinational, valid in the same cycle as the last pattern bit
dout_reg  output  1  dout_bit registered; asserts 1 cycle after dout_bit
match_cnt  output  CNT_W  number of matches, saturating
cnt_sat  output  1  sticky flag; set when match_cnt reaches its maximum value

Behaviour:
- Reset (rst=0 at a rising edge):
  - hist=0, fill=0, pat_reg=PATTERN.
  - dout_reg=0, match_cnt=0, cnt_sat=0.
  - dout_bit is forced to 0 combinationally while rst=0.
- State:
  - hist[PAT_LEN-1:0] is the shift history.
  - fill is the FSM state S0..S(PAT_LEN), encoded as a saturating count of valid bits since reset, reload, or a non-overlap match.
- Shift: on din_valid=1, hist <= {hist[PAT_LEN-2:0], din_bit} and fill <= min(fill+1, PAT_LEN).
- Mealy match: dout_bit = rst & din_valid & (fill >= PAT_LEN-1) & ({hist[PAT_LEN-2:0], din_bit} == pat_reg).
- din_valid=0:
  - hist and fill hold.
  - dout_bit=0.
  - din_bit is ignored.
  - A gap never breaks a partial match.
- Overlap mode:
  - OVERLAP=1: on a match, fill stays at PAT_LEN and the next match may reuse trailing bits.
  - OVERLAP=0: on a match, fill <= 0 (hist still shifts), so the next match needs PAT_LEN fresh bits.
- dout_reg <= dout_bit every cycle. It is 0 in the cycle after reset.
- Counter:
  - On dout_bit=1, match_cnt <= match_cnt+1 unless it is already all-ones; it then holds.
  - cnt_sat <= 1 when match_cnt becomes all-ones.
  - cnt_sat stays set until clr_cnt or reset.
- clr_cnt priority:
  - clr_cnt=1 gives match_cnt <= 0 and cnt_sat <= 0.
  - A match in the same cycle is NOT counted (clear wins).
  - dout_bit and dout_reg are unaffected by clr_cnt.
- cfg_we:
  - pat_reg <= cfg_pattern and fill <= 0; hist is retained.
  - In the cycle cfg_we=1, matching uses the old pat_reg and the counter updates normally.
  - If din_valid=1 in the same cycle, the bit is shifted into hist, but fill still ends at 0.
- Reset precedence: rst=0 overrides cfg_we, clr_cnt and din_valid. Reset mid-pattern discards the partial match.
- Width rule: the comparison is exactly PAT_LEN bits; no X-propagation from unfilled hist bits, because the fill gating covers them.

Test Plan:
1. Reset: rst=0 for 2 cycles with din_valid=1, din_bit=1 -> dout_bit=0, dout_reg=0, match_cnt=0, cnt_sat=0.
2. OVERLAP=1, PATTERN=1011, bits 1,0,1,1,0,1,1 on consecutive valid cycles -> dout_bit=1 on bits 4 and 7 only; dout_reg=1 one cycle after each; match_cnt=2.
3. OVERLAP=0, same stream -> dout_bit=1 on bit 4 only; match_cnt=1.
4. Valid gaps and reset mid-pattern:
   - Bits 1,0, then 3 cycles with din_valid=0 and din_bit=1, then bits 1,1 -> single match on the final bit.
   - Separately, bits 1,0,1, then rst=0 for 1 cycle, then bit 1 -> no match.
5. CNT_W=2: 4 matches -> match_cnt=3, cnt_sat=1 after the 3rd match; the 4th match leaves match_cnt at 3. Then clr_cnt=1 in the same cycle as a 5th match -> match_cnt=0, cnt_sat=0, dout_bit=1.
6. cfg_we with cfg_pattern=0110 after bits 1,0,1 -> no match on a following 1. Then bits 0,1,1,0 -> dout_bit=1 on the last bit; match_cnt increments by 1.
